// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini-SRC datapath: word width, ALU opcodes and
// the bus source ordering used by the priority mux.
package mini_src_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_AND  = 5'b00010;
   localparam logic [4:0] ALU_OR   = 5'b00011;
   localparam logic [4:0] ALU_SHR  = 5'b00100;
   localparam logic [4:0] ALU_SHRA = 5'b00101;
   localparam logic [4:0] ALU_SHL  = 5'b00110;
   localparam logic [4:0] ALU_ROR  = 5'b00111;
   localparam logic [4:0] ALU_ROL  = 5'b01000;
   localparam logic [4:0] ALU_NEG  = 5'b01001;
   localparam logic [4:0] ALU_NOT  = 5'b01010;
   localparam logic [4:0] ALU_MUL  = 5'b01011;
   localparam logic [4:0] ALU_DIV  = 5'b01100;

   // Bus source slots, lowest index wins when several out-strobes are high.
   localparam int NUM_GPR    = 16;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHIGH  = 18;
   localparam int SRC_ZLOW   = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_INPORT = 22;
   localparam int SRC_C      = 23;
   localparam int NUM_SRC    = 24;

endpackage

// File: rtl/mini_src_datapath_reg32.sv
// 32-bit load-enable register with synchronous active-high clear; the
// building block for every architectural register of the datapath.
module reg32
   import mini_src_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              enable,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   logic [WORD_W-1:0] q_d;
   logic [WORD_W-1:0] q_q;

   // NOTE: default-assign first so a false enable holds the value instead of inferring a latch.
   always_comb begin
      q_d = q_q;
      if (enable) q_d = d;
   end

   // NOTE: non-blocking in clocked logic so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (clear) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/mini_src_datapath.sv
// Mini-SRC single-bus datapath: register file, special registers, 64-bit Z
// and a combinational ALU, all steered by one-hot in/out strobes.
module mini_src_datapath
   import mini_src_pkg::*;
(
   input  logic              clock,
   input  logic              clear,
   input  logic              R0in,
   input  logic              R1in,
   input  logic              R2in,
   input  logic              R3in,
   input  logic              R4in,
   input  logic              R5in,
   input  logic              R6in,
   input  logic              R7in,
   input  logic              R8in,
   input  logic              R9in,
   input  logic              R10in,
   input  logic              R11in,
   input  logic              R12in,
   input  logic              R13in,
   input  logic              R14in,
   input  logic              R15in,
   input  logic              HIin,
   input  logic              LOin,
   input  logic              Zhighin,
   input  logic              Zlowin,
   input  logic              PCin,
   input  logic              MDRin,
   input  logic              In_Portin,
   input  logic              Coutin,
   input  logic              Read,
   input  logic              IRin,
   input  logic              MARin,
   input  logic              Yin,
   input  logic              Zin,
   input  logic              R0out,
   input  logic              R1out,
   input  logic              R2out,
   input  logic              R3out,
   input  logic              R4out,
   input  logic              R5out,
   input  logic              R6out,
   input  logic              R7out,
   input  logic              R8out,
   input  logic              R9out,
   input  logic              R10out,
   input  logic              R11out,
   input  logic              R12out,
   input  logic              R13out,
   input  logic              R14out,
   input  logic              R15out,
   input  logic              HIout,
   input  logic              LOout,
   input  logic              Zhighout,
   input  logic              Zlowout,
   input  logic              PCout,
   input  logic              MDRout,
   input  logic              In_Portout,
   input  logic              Coutout,
   input  logic              IncPC,
   input  logic [WORD_W-1:0] Mdatain,
   input  logic [4:0]        ALU_Control,
   output logic [WORD_W-1:0] Out_Portout
);

   word_t                bus;
   word_t                r_q [NUM_GPR];
   word_t                src [NUM_SRC];
   logic [NUM_GPR-1:0]   r_in;
   logic [NUM_SRC-1:0]   out_sel;
   word_t                hi_q, lo_q, pc_q, mdr_q, ir_q, mar_q, y_q, inport_q, c_q;
   word_t                zhigh_q, zlow_q;
   word_t                mdr_d, zhigh_d, zlow_d;
   word_t                alu_hi, alu_lo;

   assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   assign out_sel = {Coutout, In_Portout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                     R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

   reg32 R0  (.clock(clock), .clear(clear), .enable(r_in[0]),  .d(bus), .q(r_q[0]));
   reg32 R1  (.clock(clock), .clear(clear), .enable(r_in[1]),  .d(bus), .q(r_q[1]));
   reg32 R2  (.clock(clock), .clear(clear), .enable(r_in[2]),  .d(bus), .q(r_q[2]));
   reg32 R3  (.clock(clock), .clear(clear), .enable(r_in[3]),  .d(bus), .q(r_q[3]));
   reg32 R4  (.clock(clock), .clear(clear), .enable(r_in[4]),  .d(bus), .q(r_q[4]));
   reg32 R5  (.clock(clock), .clear(clear), .enable(r_in[5]),  .d(bus), .q(r_q[5]));
   reg32 R6  (.clock(clock), .clear(clear), .enable(r_in[6]),  .d(bus), .q(r_q[6]));
   reg32 R7  (.clock(clock), .clear(clear), .enable(r_in[7]),  .d(bus), .q(r_q[7]));
   reg32 R8  (.clock(clock), .clear(clear), .enable(r_in[8]),  .d(bus), .q(r_q[8]));
   reg32 R9  (.clock(clock), .clear(clear), .enable(r_in[9]),  .d(bus), .q(r_q[9]));
   reg32 R10 (.clock(clock), .clear(clear), .enable(r_in[10]), .d(bus), .q(r_q[10]));
   reg32 R11 (.clock(clock), .clear(clear), .enable(r_in[11]), .d(bus), .q(r_q[11]));
   reg32 R12 (.clock(clock), .clear(clear), .enable(r_in[12]), .d(bus), .q(r_q[12]));
   reg32 R13 (.clock(clock), .clear(clear), .enable(r_in[13]), .d(bus), .q(r_q[13]));
   reg32 R14 (.clock(clock), .clear(clear), .enable(r_in[14]), .d(bus), .q(r_q[14]));
   reg32 R15 (.clock(clock), .clear(clear), .enable(r_in[15]), .d(bus), .q(r_q[15]));

   assign mdr_d = Read ? Mdatain : bus;

   // A full-width Zin overrides any half-load in the same cycle.
   assign zhigh_d = Zin ? alu_hi : bus;
   assign zlow_d  = Zin ? alu_lo : bus;

   reg32 HI     (.clock(clock), .clear(clear), .enable(HIin),           .d(bus),     .q(hi_q));
   reg32 LO     (.clock(clock), .clear(clear), .enable(LOin),           .d(bus),     .q(lo_q));
   reg32 PC     (.clock(clock), .clear(clear), .enable(PCin),           .d(bus),     .q(pc_q));
   reg32 MDR    (.clock(clock), .clear(clear), .enable(MDRin),          .d(mdr_d),   .q(mdr_q));
   reg32 IR     (.clock(clock), .clear(clear), .enable(IRin),           .d(bus),     .q(ir_q));
   reg32 MAR    (.clock(clock), .clear(clear), .enable(MARin),          .d(bus),     .q(mar_q));
   reg32 Y      (.clock(clock), .clear(clear), .enable(Yin),            .d(bus),     .q(y_q));
   reg32 InPort (.clock(clock), .clear(clear), .enable(In_Portin),      .d(bus),     .q(inport_q));
   reg32 C      (.clock(clock), .clear(clear), .enable(Coutin),         .d(bus),     .q(c_q));
   reg32 z_high (.clock(clock), .clear(clear), .enable(Zin | Zhighin),  .d(zhigh_d), .q(zhigh_q));
   reg32 z_low  (.clock(clock), .clear(clear), .enable(Zin | Zlowin),   .d(zlow_d),  .q(zlow_q));

   // IR and MAR feed the control unit and memory, which live outside this block.
   logic unused_ext_regs;
   assign unused_ext_regs = ^{ir_q, mar_q};

   for (genvar i = 0; i < NUM_GPR; i++) begin : g_gpr_src
      assign src[i] = r_q[i];
   end
   assign src[SRC_HI]     = hi_q;
   assign src[SRC_LO]     = lo_q;
   assign src[SRC_ZHIGH]  = zhigh_q;
   assign src[SRC_ZLOW]   = zlow_q;
   assign src[SRC_PC]     = pc_q;
   assign src[SRC_MDR]    = mdr_q;
   assign src[SRC_INPORT] = inport_q;
   assign src[SRC_C]      = c_q;

   // Scanning downward lets the lowest-numbered asserted source win.
   always_comb begin
      bus = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (out_sel[i]) bus = src[i];
      end
   end

   assign Out_Portout = bus;

   word_t              a_op, b_op;
   logic [4:0]         shamt;
   logic signed [63:0] prod;
   logic signed [31:0] quo, rem;

   assign a_op  = y_q;
   assign b_op  = bus;
   assign shamt = b_op[4:0];

   always_comb begin
      alu_hi = '0;
      alu_lo = '0;
      prod   = $signed({{32{a_op[31]}}, a_op}) * $signed({{32{b_op[31]}}, b_op});
      quo    = '0;
      rem    = '0;
      if (b_op != '0) begin
         quo = $signed(a_op) / $signed(b_op);
         rem = $signed(a_op) % $signed(b_op);
      end
      if (IncPC) begin
         alu_lo = b_op + 32'd1;
      end else begin
         case (ALU_Control)
            ALU_ADD:  alu_lo = a_op + b_op;
            ALU_SUB:  alu_lo = a_op - b_op;
            ALU_AND:  alu_lo = a_op & b_op;
            ALU_OR:   alu_lo = a_op | b_op;
            ALU_SHR:  alu_lo = a_op >> shamt;
            ALU_SHRA: alu_lo = $unsigned($signed(a_op) >>> shamt);
            ALU_SHL:  alu_lo = a_op << shamt;
            ALU_ROR:  alu_lo = (a_op >> shamt) | (a_op << (6'd32 - {1'b0, shamt}));
            ALU_ROL:  alu_lo = (a_op << shamt) | (a_op >> (6'd32 - {1'b0, shamt}));
            ALU_NEG:  alu_lo = 32'd0 - b_op;
            ALU_NOT:  alu_lo = ~b_op;
            ALU_MUL: begin
               alu_hi = prod[63:32];
               alu_lo = prod[31:0];
            end
            ALU_DIV: begin
               alu_hi = rem;
               alu_lo = quo;
            end
            default: alu_lo = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mini_src_datapath.sv
// Directed bench for mini_src_datapath: stimulus pushes expected register
// and bus values into a scoreboard that a negedge monitor drains.
module tb_mini_src_datapath;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] r_in, r_out;
   logic        HIin, LOin, Zhighin, Zlowin, PCin, MDRin, In_Portin, Coutin;
   logic        Read, IRin, MARin, Yin, Zin;
   logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout;
   logic        IncPC;
   logic [31:0] Mdatain;
   logic [4:0]  ALU_Control;
   logic [31:0] Out_Portout;

   always #5 clock = ~clock;

   mini_src_datapath dut (
      .clock(clock), .clear(clear),
      .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
      .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
      .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
      .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
      .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
      .PCin(PCin), .MDRin(MDRin), .In_Portin(In_Portin), .Coutin(Coutin),
      .Read(Read), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin),
      .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
      .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
      .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
      .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
      .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .PCout(PCout), .MDRout(MDRout), .In_Portout(In_Portout), .Coutout(Coutout),
      .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
      .Out_Portout(Out_Portout)
   );

   localparam int P_BUS = 0, P_R2 = 1, P_R5 = 2, P_R6 = 3, P_HI = 4, P_PC = 5,
                  P_MDR = 6, P_IR = 7, P_MAR = 8, P_Y = 9, P_ZH = 10, P_ZL = 11;

   logic [31:0] r2_q, r5_q, r6_q, hi_q, pc_q, mdr_q, ir_q, mar_q, y_q, zh_q, zl_q;
   assign r2_q  = dut.R2.q;
   assign r5_q  = dut.R5.q;
   assign r6_q  = dut.R6.q;
   assign hi_q  = dut.HI.q;
   assign pc_q  = dut.PC.q;
   assign mdr_q = dut.MDR.q;
   assign ir_q  = dut.IR.q;
   assign mar_q = dut.MAR.q;
   assign y_q   = dut.Y.q;
   assign zh_q  = dut.z_high.q;
   assign zl_q  = dut.z_low.q;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         P_BUS:   return Out_Portout;
         P_R2:    return r2_q;
         P_R5:    return r5_q;
         P_R6:    return r6_q;
         P_HI:    return hi_q;
         P_PC:    return pc_q;
         P_MDR:   return mdr_q;
         P_IR:    return ir_q;
         P_MAR:   return mar_q;
         P_Y:     return y_q;
         P_ZH:    return zh_q;
         P_ZL:    return zl_q;
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Monitor: results are stable at the falling edge, half a cycle from any load.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, observe(e.sel), e.exp);
         end
      end
   end

   task automatic idle();
      clear = 0; r_in = '0; r_out = '0;
      HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0; PCin = 0; MDRin = 0; In_Portin = 0; Coutin = 0;
      Read = 0; IRin = 0; MARin = 0; Yin = 0; Zin = 0;
      HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0; In_Portout = 0; Coutout = 0;
      IncPC = 0; ALU_Control = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   // Y <= a, then bus = b with the opcode; optionally also raise both half-loads.
   task automatic alu_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic halves,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      Mdatain = a; Read = 1; MDRin = 1; tick();
      MDRout = 1; Yin = 1; tick();
      Mdatain = b; Read = 1; MDRin = 1; tick();
      MDRout = 1; ALU_Control = op; Zin = 1; Zhighin = halves; Zlowin = halves; tick();
      expect_val({name, "_zhi"}, P_ZH, exp_hi);
      expect_val({name, "_zlo"}, P_ZL, exp_lo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      Mdatain = '0;
      @(negedge clock);
      clear = 1; tick();
      expect_val("reset_r5", P_R5, 32'h0);
      expect_val("reset_pc", P_PC, 32'h0);
      expect_val("reset_zlo", P_ZL, 32'h0);
      expect_val("reset_bus", P_BUS, 32'h0);

      Mdatain = 32'h45; Read = 1; MDRin = 1; tick();
      expect_val("mdr_read_45", P_MDR, 32'h45);
      MDRout = 1; r_in[5] = 1;
      expect_val("bus_mdr_45", P_BUS, 32'h45);
      tick();
      expect_val("r5_load", P_R5, 32'h45);
      Mdatain = 32'h23; Read = 1; MDRin = 1; tick();
      MDRout = 1; r_in[6] = 1; tick();
      expect_val("r6_load", P_R6, 32'h23);

      // Fetch T0..T2 from PC = 0
      PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
      expect_val("t0_mar", P_MAR, 32'h0);
      expect_val("t0_zlo", P_ZL, 32'h1);
      expect_val("t0_zhi", P_ZH, 32'h0);
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h112B_0000; tick();
      expect_val("t1_pc", P_PC, 32'h1);
      expect_val("t1_mdr", P_MDR, 32'h112B_0000);
      MDRout = 1; IRin = 1; tick();
      expect_val("t2_ir", P_IR, 32'h112B_0000);

      // Bus priority: R5 beats PC; InPort beats C
      r_out[5] = 1; PCout = 1;
      expect_val("prio_r5_pc", P_BUS, 32'h45);
      tick();
      r_out[6] = 1; In_Portin = 1; tick();
      In_Portout = 1; Coutout = 1;
      expect_val("prio_inport_c", P_BUS, 32'h23);
      tick();

      // SUB R2 = R5 - R6
      r_out[5] = 1; Yin = 1; tick();
      expect_val("sub_y", P_Y, 32'h45);
      r_out[6] = 1; ALU_Control = 5'b00001; Zin = 1; tick();
      expect_val("sub_zlo", P_ZL, 32'h22);
      Zlowout = 1; r_in[2] = 1; tick();
      expect_val("sub_r2", P_R2, 32'h22);

      alu_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 5'b00000, 1'b0, 32'h0, 32'h0);
      alu_op("mul", 32'h0001_0000, 32'h0001_0000, 5'b01011, 1'b0, 32'h1, 32'h0);
      Zhighout = 1; HIin = 1; tick();
      expect_val("hi_from_zhigh", P_HI, 32'h1);
      alu_op("div_signed", 32'hFFFF_FFF9, 32'h2, 5'b01100, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      alu_op("div_zero", 32'h0000_0064, 32'h0, 5'b01100, 1'b0, 32'h0, 32'h0);
      alu_op("shra", 32'h8000_0000, 32'h4, 5'b00101, 1'b0, 32'h0, 32'hF800_0000);
      alu_op("ror", 32'h0000_0001, 32'h1, 5'b00111, 1'b0, 32'h0, 32'h8000_0000);
      alu_op("unused_op", 32'h1234_5678, 32'h1, 5'b11111, 1'b0, 32'h0, 32'h0);
      alu_op("zin_wins", 32'h3, 32'h4, 5'b00000, 1'b1, 32'h0, 32'h7);

      // Clear while R2 is being loaded
      MDRout = 1; r_in[2] = 1; clear = 1; tick();
      expect_val("clr_r2", P_R2, 32'h0);
      expect_val("clr_r5", P_R5, 32'h0);
      expect_val("clr_hi", P_HI, 32'h0);
      expect_val("clr_pc", P_PC, 32'h0);
      expect_val("clr_mdr", P_MDR, 32'h0);
      expect_val("clr_ir", P_IR, 32'h0);
      expect_val("clr_y", P_Y, 32'h0);
      expect_val("clr_zhi", P_ZH, 32'h0);
      expect_val("clr_zlo", P_ZL, 32'h0);
      expect_val("clr_bus", P_BUS, 32'h0);

      repeat (2) @(negedge clock);
      #1;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         $display("FAIL %s: never compared, expected 0x%08h", e.name, e.exp);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
